mcpu_prog_loader: RTL and testbench

- Boot-time program loader sitting directly upstream of the MCPU core and its RAM.
- Receives a byte stream over a valid/ready handshake and assembles 16-bit instruction words, high byte first.
- Writes the words into consecutive RAM addresses starting at 0.
- Holds the CPU in reset until the image is fully loaded, then releases it so execution starts at address 0.

---
 rtl/mcpu_pkg.sv | 51 +++++
 rtl/mcpu_loader_fsm.sv | 128 ++++++++++++
 rtl/mcpu_prog_loader.sv | 69 ++++++
 tb/tb_mcpu_prog_loader.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcpu_pkg.sv
// Shared MCPU definitions: word/address widths, loader state encoding and
// the per-state control decode used by the program loader.
package mcpu_pkg;

  localparam int MCPU_ADDR_W = 8;
  localparam int MCPU_WORD_W = 16;
  localparam int MCPU_BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    HI,
    LO,
    WR,
    DONE,
    CHK,
    ERR
  } state_t;

  typedef struct packed {
    logic in_ready;
    logic mem_we;
    logic cpu_reset;
    logic busy;
    logic done;
  } ctl_t;

  // Control outputs are registered alongside the state, so they are decoded
  // from the state being entered rather than the current one.
  function automatic ctl_t decode_ctl(input state_t s);
    ctl_t c;
    c = '{in_ready: 1'b0, mem_we: 1'b0, cpu_reset: 1'b1, busy: 1'b0, done: 1'b0};
    case (s)
      LEN, HI, LO, CHK: begin
        c.in_ready = 1'b1;
        c.busy     = 1'b1;
      end
      WR: begin
        c.mem_we = 1'b1;
        c.busy   = 1'b1;
      end
      DONE: begin
        c.cpu_reset = 1'b0;
        c.done      = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mcpu_loader_fsm.sv
// Loader state machine: state register, registered controls, write address,
// remaining-word counter and (with MCPU_LOADER_CHKSUM_EN) checksum/err.
module mcpu_loader_fsm
  import mcpu_pkg::*;
#(
  parameter int ADDR_W = MCPU_ADDR_W,
  parameter int BYTE_W = MCPU_BYTE_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_data,
  output state_t            state,
  output ctl_t              ctl,
  output logic [ADDR_W-1:0] addr,
  output logic              err
);

  localparam int CNT_W = BYTE_W + 1;

  logic [CNT_W-1:0] remaining;
  logic             xfer;

  assign xfer = in_valid && ctl.in_ready;

`ifdef MCPU_LOADER_CHKSUM_EN
  logic [BYTE_W-1:0] acc;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ctl       <= decode_ctl(IDLE);
      addr      <= '0;
      remaining <= '0;
`ifdef MCPU_LOADER_CHKSUM_EN
      acc       <= '0;
      err       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE
`ifdef MCPU_LOADER_CHKSUM_EN
        , ERR
`endif
        : begin
          if (start) begin
            state     <= LEN;
            ctl       <= decode_ctl(LEN);
            addr      <= '0;
            remaining <= '0;
`ifdef MCPU_LOADER_CHKSUM_EN
            acc       <= '0;
            err       <= 1'b0;
`endif
          end
        end
        LEN: begin
          if (xfer) begin
            // A zero length byte stands for a full 2^BYTE_W-word image.
            remaining <= (in_data == '0) ? {1'b1, {BYTE_W{1'b0}}} : {1'b0, in_data};
            state     <= HI;
            ctl       <= decode_ctl(HI);
`ifdef MCPU_LOADER_CHKSUM_EN
            acc       <= acc ^ in_data;
`endif
          end
        end
        HI: begin
          if (xfer) begin
            state <= LO;
            ctl   <= decode_ctl(LO);
`ifdef MCPU_LOADER_CHKSUM_EN
            acc   <= acc ^ in_data;
`endif
          end
        end
        LO: begin
          if (xfer) begin
            state <= WR;
            ctl   <= decode_ctl(WR);
`ifdef MCPU_LOADER_CHKSUM_EN
            acc   <= acc ^ in_data;
`endif
          end
        end
        WR: begin
          addr      <= addr + 1'b1;
          remaining <= remaining - 1'b1;
          if (remaining == CNT_W'(1)) begin
`ifdef MCPU_LOADER_CHKSUM_EN
            state <= CHK;
            ctl   <= decode_ctl(CHK);
`else
            state <= DONE;
            ctl   <= decode_ctl(DONE);
`endif
          end else begin
            state <= HI;
            ctl   <= decode_ctl(HI);
          end
        end
`ifdef MCPU_LOADER_CHKSUM_EN
        CHK: begin
          if (xfer) begin
            if (in_data == acc) begin
              state <= DONE;
              ctl   <= decode_ctl(DONE);
            end else begin
              err   <= 1'b1;
              state <= ERR;
              ctl   <= decode_ctl(ERR);
            end
          end
        end
`endif
        default: begin
          state <= IDLE;
          ctl   <= decode_ctl(IDLE);
        end
      endcase
    end
  end

endmodule

// File: rtl/mcpu_prog_loader.sv
// Boot-time program loader: assembles HI/LO bytes into words, writes them to
// RAM from address 0 and holds the MCPU in reset until the image is loaded.
// Optional trailing checksum byte: define MCPU_LOADER_CHKSUM_EN.
module mcpu_prog_loader
  import mcpu_pkg::*;
#(
  parameter int ADDR_W = MCPU_ADDR_W,
  parameter int WORD_W = MCPU_WORD_W,
  parameter int BYTE_W = MCPU_BYTE_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_t            state;
  ctl_t              ctl;
  logic              xfer;
  logic [BYTE_W-1:0] hi;
  logic [WORD_W-1:0] wdata;

  mcpu_loader_fsm #(
    .ADDR_W(ADDR_W),
    .BYTE_W(BYTE_W)
  ) u_fsm (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .in_valid(in_valid),
    .in_data (in_data),
    .state   (state),
    .ctl     (ctl),
    .addr    (mem_addr),
    .err     (err)
  );

  assign xfer = in_valid && ctl.in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      hi    <= '0;
      wdata <= '0;
    end else if (xfer) begin
      if (state == HI) begin
        hi <= in_data;
      end else if (state == LO) begin
        wdata <= {hi, in_data};
      end
    end
  end

  assign mem_wdata = wdata;
  assign in_ready  = ctl.in_ready;
  assign mem_we    = ctl.mem_we;
  assign cpu_reset = ctl.cpu_reset;
  assign busy      = ctl.busy;
  assign done      = ctl.done;

endmodule

// File: tb/tb_mcpu_prog_loader.sv
// Directed self-checking bench for mcpu_prog_loader (default build, checksum
// option compiled out). Inputs change and outputs are checked on negedge.
module tb_mcpu_prog_loader;

  logic        clk = 1'b0;
  logic        reset, start, in_valid;
  logic [7:0]  in_data;
  logic        in_ready, mem_we, cpu_reset, busy, done, err;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;

  int total = 0;
  int bad   = 0;

  logic [15:0] ram [256];
  int          wr_count = 0;
  logic [7:0]  last_addr = 8'h00;

  always #5 clk = ~clk;

  mcpu_prog_loader #(
    .ADDR_W(8),
    .WORD_W(16),
    .BYTE_W(8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .cpu_reset(cpu_reset),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  // Behavioural RAM on the write port
  always @(posedge clk) begin
    if (mem_we === 1'b1) begin
      ram[mem_addr] <= mem_wdata;
      wr_count      <= wr_count + 1;
      last_addr     <= mem_addr;
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit stall);
    int guard;
    if (stall) begin
      in_valid = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    guard    = 0;
    while (in_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL send_byte %h: in_ready=%b required 1 within 20 cycles", b, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (2) @(negedge clk);
    total++;
    if ({in_ready, mem_we, cpu_reset, busy, done, err} !== 6'b001000) begin
      bad++;
      $display("FAIL reset_ctl: {rdy,we,cpurst,busy,done,err}=%b required 001000",
               {in_ready, mem_we, cpu_reset, busy, done, err});
    end
    total++;
    if (mem_addr !== 8'h00 || mem_wdata !== 16'h0000) begin
      bad++;
      $display("FAIL reset_mem: addr=%h wdata=%h required 00/0000", mem_addr, mem_wdata);
    end
    reset = 1'b0;
    in_valid = 1'b1; in_data = 8'h02;
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    total++;
    if (in_ready !== 1'b0 || busy !== 1'b0 || cpu_reset !== 1'b1) begin
      bad++;
      $display("FAIL idle_hold: rdy=%b busy=%b cpurst=%b required 0/0/1", in_ready, busy, cpu_reset);
    end
  endtask

  task automatic test_basic();
    int base;
    base = wr_count;
    pulse_start();
    total++;
    if (busy !== 1'b1 || in_ready !== 1'b1 || cpu_reset !== 1'b1) begin
      bad++;
      $display("FAIL basic_len: busy=%b rdy=%b cpurst=%b required 1/1/1", busy, in_ready, cpu_reset);
    end
    send_byte(8'h02, 1'b0);
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    total++;
    if (mem_we !== 1'b1 || mem_addr !== 8'h00 || mem_wdata !== 16'h1234 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL basic_wr0: we=%b addr=%h data=%h rdy=%b required 1/00/1234/0",
               mem_we, mem_addr, mem_wdata, in_ready);
    end
    send_byte(8'hAB, 1'b0);
    send_byte(8'hCD, 1'b0);
    total++;
    if (mem_we !== 1'b1 || mem_addr !== 8'h01 || mem_wdata !== 16'hABCD || done !== 1'b0) begin
      bad++;
      $display("FAIL basic_wr1: we=%b addr=%h data=%h done=%b required 1/01/ABCD/0",
               mem_we, mem_addr, mem_wdata, done);
    end
    @(negedge clk);
    total++;
    if (mem_we !== 1'b0 || done !== 1'b1 || cpu_reset !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL basic_done: we=%b done=%b cpurst=%b busy=%b required 0/1/0/0",
               mem_we, done, cpu_reset, busy);
    end
    total++;
    if (wr_count - base != 2 || ram[0] !== 16'h1234 || ram[1] !== 16'hABCD) begin
      bad++;
      $display("FAIL basic_ram: writes=%0d ram0=%h ram1=%h required 2/1234/ABCD",
               wr_count - base, ram[0], ram[1]);
    end
  endtask

  task automatic test_stalls();
    int base;
    base = wr_count;
    pulse_start();
    total++;
    if (cpu_reset !== 1'b1 || done !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL stall_restart: cpurst=%b done=%b busy=%b required 1/0/1", cpu_reset, done, busy);
    end
    send_byte(8'h02, 1'b1);
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    total++;
    if (in_ready !== 1'b0 || mem_we !== 1'b1 || mem_wdata !== 16'h1234) begin
      bad++;
      $display("FAIL stall_wr0: rdy=%b we=%b data=%h required 0/1/1234", in_ready, mem_we, mem_wdata);
    end
    send_byte(8'hAB, 1'b1);
    send_byte(8'hCD, 1'b1);
    total++;
    if (in_ready !== 1'b0 || mem_we !== 1'b1 || mem_addr !== 8'h01 || mem_wdata !== 16'hABCD) begin
      bad++;
      $display("FAIL stall_wr1: rdy=%b we=%b addr=%h data=%h required 0/1/01/ABCD",
               in_ready, mem_we, mem_addr, mem_wdata);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b1 || wr_count - base != 2 || ram[0] !== 16'h1234 || ram[1] !== 16'hABCD) begin
      bad++;
      $display("FAIL stall_ram: done=%b writes=%0d ram0=%h ram1=%h required 1/2/1234/ABCD",
               done, wr_count - base, ram[0], ram[1]);
    end
  endtask

  task automatic test_full_image();
    int base;
    int wr_errs;
    int ram_errs;
    base     = wr_count;
    wr_errs  = 0;
    ram_errs = 0;
    pulse_start();
    send_byte(8'h00, 1'b0);
    for (int k = 0; k < 256; k++) begin
      send_byte(8'h00, 1'b0);
      send_byte(k[7:0], 1'b0);
      if (mem_we !== 1'b1 || mem_addr !== k[7:0] || mem_wdata !== {8'h00, k[7:0]}) wr_errs++;
      if (k < 255 && done !== 1'b0) wr_errs++;
    end
    total++;
    if (wr_errs != 0) begin
      bad++;
      $display("FAIL full_writes: %0d write cycles wrong, required 0", wr_errs);
    end
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL full_early_done: done=%b during last write, required 0", done);
    end
    @(negedge clk);
    for (int k = 0; k < 256; k++) begin
      if (ram[k] !== k[15:0]) ram_errs++;
    end
    total++;
    if (done !== 1'b1 || wr_count - base != 256 || last_addr !== 8'hFF) begin
      bad++;
      $display("FAIL full_done: done=%b writes=%0d last_addr=%h required 1/256/FF",
               done, wr_count - base, last_addr);
    end
    total++;
    if (mem_addr !== 8'h00 || ram_errs != 0) begin
      bad++;
      $display("FAIL full_wrap: addr=%h ram_errs=%0d required 00/0", mem_addr, ram_errs);
    end
  endtask

  task automatic test_mid_reset();
    int base;
    base = wr_count;
    pulse_start();
    send_byte(8'h02, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++;
    if (busy !== 1'b0 || cpu_reset !== 1'b1 || in_ready !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL midreset_idle: busy=%b cpurst=%b rdy=%b done=%b required 0/1/0/0",
               busy, cpu_reset, in_ready, done);
    end
    total++;
    if (wr_count - base != 1 || ram[0] !== 16'h1122) begin
      bad++;
      $display("FAIL midreset_kept: writes=%0d ram0=%h required 1/1122", wr_count - base, ram[0]);
    end
    // start arrives together with a valid byte while idle
    base     = wr_count;
    start    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h02;
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL start_idle_rdy: rdy=%b required 0", in_ready);
    end
    @(negedge clk);
    start = 1'b0;
    total++;
    if (in_ready !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL start_idle_len: rdy=%b busy=%b required 1/1", in_ready, busy);
    end
    send_byte(8'h02, 1'b0);
    send_byte(8'h77, 1'b0);
    send_byte(8'h88, 1'b0);
    send_byte(8'h99, 1'b0);
    send_byte(8'hAA, 1'b0);
    @(negedge clk);
    total++;
    if (done !== 1'b1 || wr_count - base != 2 || ram[0] !== 16'h7788 || ram[1] !== 16'h99AA) begin
      bad++;
      $display("FAIL midreset_reload: done=%b writes=%0d ram0=%h ram1=%h required 1/2/7788/99AA",
               done, wr_count - base, ram[0], ram[1]);
    end
  endtask

  task automatic test_start_busy();
    int base;
    base = wr_count;
    pulse_start();
    send_byte(8'h01, 1'b0);
    send_byte(8'h9E, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_byte(8'h0F, 1'b0);
    total++;
    if (mem_we !== 1'b1 || mem_addr !== 8'h00 || mem_wdata !== 16'h9E0F) begin
      bad++;
      $display("FAIL busy_start_wr: we=%b addr=%h data=%h required 1/00/9E0F", mem_we, mem_addr, mem_wdata);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b1 || wr_count - base != 1 || ram[0] !== 16'h9E0F) begin
      bad++;
      $display("FAIL busy_start_done: done=%b writes=%0d ram0=%h required 1/1/9E0F",
               done, wr_count - base, ram[0]);
    end
    base = wr_count;
    pulse_start();
    total++;
    if (cpu_reset !== 1'b1 || done !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL reload_cpurst: cpurst=%b done=%b busy=%b required 1/0/1", cpu_reset, done, busy);
    end
    send_byte(8'h01, 1'b0);
    send_byte(8'h55, 1'b0);
    send_byte(8'hAA, 1'b0);
    @(negedge clk);
    total++;
    if (done !== 1'b1 || cpu_reset !== 1'b0 || wr_count - base != 1 || ram[0] !== 16'h55AA) begin
      bad++;
      $display("FAIL reload_done: done=%b cpurst=%b writes=%0d ram0=%h required 1/0/1/55AA",
               done, cpu_reset, wr_count - base, ram[0]);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stalls();
    test_full_image();
    test_mid_reset();
    test_start_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
